// File: rtl/can_tx_queue.sv
// CAN transmit frame queue: FIFO of complete frames feeding can_top.
// Sequences start_tx against busy/done/arb-lost/error and retries failures.
module can_tx_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_RETRY = 3,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  // Host write side
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic          wr_ide,
  input  logic          wr_rtr,
  input  logic [10:0]   wr_id_std,
  input  logic [28:0]   wr_id_ext,
  input  logic [3:0]    wr_dlc,
  input  logic [63:0]   wr_data,
  // can_top transmit side
  output logic          start_tx,
  output logic          ide,
  output logic          rtr,
  output logic [10:0]   id_std,
  output logic [28:0]   id_ext,
  output logic [3:0]    dlc,
  output logic [63:0]   tx_data,
  input  logic          tx_busy,
  input  logic          tx_done,
  input  logic          tx_arb_lost,
  input  logic          tx_err,
  input  logic          abort_req,
  // Status
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          tx_ok,
  output logic          tx_drop,
  output logic [RW-1:0] retry_cnt
);

  typedef struct packed {
    logic        ide;
    logic        rtr;
    logic [10:0] id_std;
    logic [28:0] id_ext;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frame_t;

  typedef enum logic [1:0] {StIdle, StStart, StBusy} state_e;

  frame_t         mem_q [DEPTH];
  frame_t         head;

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  state_e         state_q, state_d;
  logic           start_tx_q, start_tx_d;
  logic           tx_ok_q, tx_ok_d;
  logic           tx_drop_q, tx_drop_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic           abort_pend_q, abort_pend_d;

  logic           push, pop, fail, drop_now;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = !full;
  assign push     = wr_valid && !full;

  // Head frame is a plain read of the slot at rd_ptr, blanked when empty.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign ide     = head.ide;
  assign rtr     = head.rtr;
  assign id_std  = head.id_std;
  assign id_ext  = head.id_ext;
  assign dlc     = head.dlc;
  assign tx_data = head.data;

  assign start_tx  = start_tx_q;
  assign tx_ok     = tx_ok_q;
  assign tx_drop   = tx_drop_q;
  assign retry_cnt = retry_q;
  assign count     = count_q;

  // A failure drops the frame when retries are used up or an abort is pending.
  assign fail     = tx_err || tx_arb_lost;
  assign drop_now = (retry_q == RW'(MAX_RETRY)) || abort_pend_q || abort_req;

  // Transmit sequencer next state and pop decision.
  always_comb begin
    state_d      = state_q;
    tx_ok_d      = 1'b0;
    tx_drop_d    = 1'b0;
    retry_d      = retry_q;
    abort_pend_d = abort_pend_q;
    pop          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) state_d = StStart;
      end
      StStart: begin
        if (abort_req) begin
          pop       = 1'b1;
          tx_drop_d = 1'b1;
          state_d   = StIdle;
        end else if (tx_busy) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (abort_req) abort_pend_d = 1'b1;
        if (tx_done) begin
          pop     = 1'b1;
          tx_ok_d = 1'b1;
          state_d = StIdle;
        end else if (fail) begin
          if (drop_now) begin
            pop       = 1'b1;
            tx_drop_d = 1'b1;
            state_d   = StIdle;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = StStart;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Every pop starts the next head with a clean slate.
    if (pop) begin
      retry_d      = '0;
      abort_pend_d = 1'b0;
    end
    start_tx_d = (state_d == StStart);
  end

  // Pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Control state with synchronous reset; queued frames are discarded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      start_tx_q   <= 1'b0;
      tx_ok_q      <= 1'b0;
      tx_drop_q    <= 1'b0;
      retry_q      <= '0;
      abort_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      start_tx_q   <= start_tx_d;
      tx_ok_q      <= tx_ok_d;
      tx_drop_q    <= tx_drop_d;
      retry_q      <= retry_d;
      abort_pend_q <= abort_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Frame storage; not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{ide: wr_ide, rtr: wr_rtr, id_std: wr_id_std, id_ext: wr_id_ext,
                           dlc: wr_dlc, data: wr_data};
    end
  end

endmodule

// File: tb/tb_can_tx_queue.sv
// Directed self-checking bench for can_tx_queue (DEPTH=4, MAX_RETRY=3).
module tb_can_tx_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, wr_ready, wr_ide, wr_rtr;
  logic [10:0] wr_id_std;
  logic [28:0] wr_id_ext;
  logic [3:0]  wr_dlc;
  logic [63:0] wr_data;
  logic        start_tx, ide, rtr;
  logic [10:0] id_std;
  logic [28:0] id_ext;
  logic [3:0]  dlc;
  logic [63:0] tx_data;
  logic        tx_busy, tx_done, tx_arb_lost, tx_err, abort_req;
  logic [2:0]  count;
  logic        full, empty, tx_ok, tx_drop;
  logic [1:0]  retry_cnt;

  int checks = 0;
  int errors = 0;

  can_tx_queue #(.DEPTH(4), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ide(wr_ide), .wr_rtr(wr_rtr),
    .wr_id_std(wr_id_std), .wr_id_ext(wr_id_ext), .wr_dlc(wr_dlc), .wr_data(wr_data),
    .start_tx(start_tx), .ide(ide), .rtr(rtr), .id_std(id_std), .id_ext(id_ext),
    .dlc(dlc), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_arb_lost(tx_arb_lost), .tx_err(tx_err), .abort_req(abort_req),
    .count(count), .full(full), .empty(empty), .tx_ok(tx_ok), .tx_drop(tx_drop),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic i_ide, input logic i_rtr, input logic [10:0] i_std,
                      input logic [28:0] i_ext, input logic [3:0] i_dlc,
                      input logic [63:0] i_data);
    wr_valid = 1'b1; wr_ide = i_ide; wr_rtr = i_rtr; wr_id_std = i_std;
    wr_id_ext = i_ext; wr_dlc = i_dlc; wr_data = i_data;
    step();
    wr_valid = 1'b0;
  endtask

  // Head in START: take it, complete it, then let the next head reach START.
  task automatic send_ok();
    tx_busy = 1'b1; step(); tx_busy = 1'b0;
    tx_done = 1'b1; step(); tx_done = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %b exp 1", wr_ready); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", full); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if ({start_tx, tx_ok, tx_drop} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b exp 000", {start_tx, tx_ok, tx_drop}); end
    checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL rst_retry got %0d exp 0", retry_cnt); end
    checks++; if ({ide, rtr, id_std, id_ext, dlc, tx_data} !== '0) begin errors++; $display("FAIL rst_head got %h exp 0", {ide, rtr, id_std, id_ext, dlc, tx_data}); end
  endtask

  task automatic test_single();
    push(1'b0, 1'b0, 11'h157, 29'h0, 4'd4, 64'h55555555);
    checks++; if (empty !== 1'b0 || start_tx !== 1'b0) begin errors++; $display("FAIL single_e1 got empty=%b start=%b exp 0 0", empty, start_tx); end
    checks++; if (id_std !== 11'h157 || dlc !== 4'd4 || tx_data !== 64'h55555555) begin errors++; $display("FAIL single_head got %h %h %h exp 157 4 55555555", id_std, dlc, tx_data); end
    step();
    checks++; if (start_tx !== 1'b1) begin errors++; $display("FAIL single_start got %b exp 1", start_tx); end
    tx_busy = 1'b1; step();
    checks++; if (start_tx !== 1'b0) begin errors++; $display("FAIL single_busy_start got %b exp 0", start_tx); end
    tx_done = 1'b1; step(); tx_done = 1'b0; tx_busy = 1'b0;
    checks++; if (tx_ok !== 1'b1 || count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_done got ok=%b cnt=%0d empty=%b exp 1 0 1", tx_ok, count, empty); end
    step();
    checks++; if (tx_ok !== 1'b0 || start_tx !== 1'b0) begin errors++; $display("FAIL single_after got ok=%b start=%b exp 0 0", tx_ok, start_tx); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 1'b0, 11'h100 + 11'(i), 29'h0, 4'd1, 64'(i));
      if (i == 3) begin
        checks++; if (full !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL full_flag got full=%b rdy=%b exp 1 0", full, wr_ready); end
      end
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (start_tx !== 1'b1 || id_std !== 11'h100 + 11'(i)) begin errors++; $display("FAIL full_order%0d got start=%b id=%h exp 1 %h", i, start_tx, id_std, 11'h100 + 11'(i)); end
      send_ok();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_fifth_ignored got empty=%b exp 1", empty); end
  endtask

  task automatic test_retry();
    push(1'b0, 1'b0, 11'h2AA, 29'h0, 4'd2, 64'hA);
    push(1'b0, 1'b0, 11'h2BB, 29'h0, 4'd2, 64'hB);
    push(1'b0, 1'b0, 11'h2CC, 29'h0, 4'd2, 64'hC);
    for (int k = 1; k <= 3; k++) begin
      tx_busy = 1'b1; step(); tx_busy = 1'b0;
      if (k == 1) tx_arb_lost = 1'b1; else tx_err = 1'b1;
      step(); tx_arb_lost = 1'b0; tx_err = 1'b0;
      checks++; if (retry_cnt !== 2'(k) || start_tx !== 1'b1 || id_std !== 11'h2AA || tx_drop !== 1'b0) begin errors++; $display("FAIL retry_a%0d got rc=%0d start=%b id=%h drop=%b exp %0d 1 2aa 0", k, retry_cnt, start_tx, id_std, tx_drop, k); end
    end
    tx_busy = 1'b1; step(); tx_busy = 1'b0;
    tx_done = 1'b1; step(); tx_done = 1'b0;
    checks++; if (tx_ok !== 1'b1 || tx_drop !== 1'b0 || retry_cnt !== 2'd0 || count !== 3'd2) begin errors++; $display("FAIL retry_ok got ok=%b drop=%b rc=%0d cnt=%0d exp 1 0 0 2", tx_ok, tx_drop, retry_cnt, count); end
    step();
    for (int k = 1; k <= 4; k++) begin
      tx_busy = 1'b1; step(); tx_busy = 1'b0;
      tx_err = 1'b1; step(); tx_err = 1'b0;
      if (k < 4) begin
        checks++; if (retry_cnt !== 2'(k) || tx_drop !== 1'b0) begin errors++; $display("FAIL retry_b%0d got rc=%0d drop=%b exp %0d 0", k, retry_cnt, tx_drop, k); end
      end else begin
        checks++; if (tx_drop !== 1'b1 || tx_ok !== 1'b0 || count !== 3'd1 || retry_cnt !== 2'd0 || id_std !== 11'h2CC) begin errors++; $display("FAIL retry_drop got drop=%b ok=%b cnt=%0d rc=%0d id=%h exp 1 0 1 0 2cc", tx_drop, tx_ok, count, retry_cnt, id_std); end
      end
    end
    step();
    send_ok();
  endtask

  task automatic test_abort();
    push(1'b0, 1'b0, 11'h011, 29'h0, 4'd0, 64'h0);
    push(1'b1, 1'b1, 11'h022, 29'h1ABCDEF0, 4'd8, 64'h0123456789ABCDEF);
    push(1'b0, 1'b0, 11'h033, 29'h0, 4'd3, 64'h333);
    abort_req = 1'b1; step(); abort_req = 1'b0;
    checks++; if (tx_drop !== 1'b1 || count !== 3'd2 || start_tx !== 1'b0) begin errors++; $display("FAIL abort_start got drop=%b cnt=%0d start=%b exp 1 2 0", tx_drop, count, start_tx); end
    checks++; if (ide !== 1'b1 || rtr !== 1'b1 || id_ext !== 29'h1ABCDEF0 || dlc !== 4'd8 || tx_data !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL abort_ext_head got %b %b %h %h %h", ide, rtr, id_ext, dlc, tx_data); end
    step();
    tx_busy = 1'b1; step(); tx_busy = 1'b0;
    abort_req = 1'b1; step(); abort_req = 1'b0;
    checks++; if (tx_drop !== 1'b0 || count !== 3'd2) begin errors++; $display("FAIL abort_busy_defer got drop=%b cnt=%0d exp 0 2", tx_drop, count); end
    tx_err = 1'b1; step(); tx_err = 1'b0;
    checks++; if (tx_drop !== 1'b1 || retry_cnt !== 2'd0 || count !== 3'd1 || id_std !== 11'h033) begin errors++; $display("FAIL abort_err got drop=%b rc=%0d cnt=%0d id=%h exp 1 0 1 033", tx_drop, retry_cnt, count, id_std); end
    step();
    tx_busy = 1'b1; step(); tx_busy = 1'b0;
    abort_req = 1'b1; step(); abort_req = 1'b0;
    tx_done = 1'b1; step(); tx_done = 1'b0;
    checks++; if (tx_ok !== 1'b1 || tx_drop !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL abort_done got ok=%b drop=%b cnt=%0d exp 1 0 0", tx_ok, tx_drop, count); end
    step();
  endtask

  task automatic test_simul();
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 11'h400 + 11'(i), 29'h0, 4'd1, 64'h0);
    tx_busy = 1'b1; step(); tx_busy = 1'b0;
    wr_valid = 1'b1; wr_id_std = 11'h403; tx_done = 1'b1;
    step();
    wr_valid = 1'b0; tx_done = 1'b0;
    checks++; if (count !== 3'd3 || tx_ok !== 1'b1 || id_std !== 11'h401) begin errors++; $display("FAIL simul got cnt=%0d ok=%b id=%h exp 3 1 401", count, tx_ok, id_std); end
    step();
    for (int i = 1; i < 4; i++) begin
      checks++; if (id_std !== 11'h400 + 11'(i)) begin errors++; $display("FAIL simul_order%0d got %h exp %h", i, id_std, 11'h400 + 11'(i)); end
      send_ok();
    end
  endtask

  task automatic test_wrap();
    push(1'b0, 1'b0, 11'h300, 29'h0, 4'd1, 64'h0);
    push(1'b0, 1'b0, 11'h301, 29'h0, 4'd1, 64'h1);
    for (int i = 0; i < 12; i++) begin
      checks++; if (start_tx !== 1'b1 || id_std !== 11'h300 + 11'(i)) begin errors++; $display("FAIL wrap%0d got start=%b id=%h exp 1 %h", i, start_tx, id_std, 11'h300 + 11'(i)); end
      tx_busy = 1'b1; step(); tx_busy = 1'b0;
      tx_done = 1'b1;
      if (i < 10) begin
        wr_valid = 1'b1; wr_id_std = 11'h302 + 11'(i); wr_data = 64'(i + 2);
      end
      step();
      tx_done = 1'b0; wr_valid = 1'b0;
      step();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty); end
  endtask

  task automatic test_rst_busy();
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 11'h500 + 11'(i), 29'h0, 4'd1, 64'h0);
    tx_busy = 1'b1; step(); tx_busy = 1'b0;
    tx_err = 1'b1; step(); tx_err = 1'b0;
    tx_busy = 1'b1; step(); tx_busy = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (count !== 3'd0 || empty !== 1'b1 || wr_ready !== 1'b1 || retry_cnt !== 2'd0) begin errors++; $display("FAIL rstb_state got cnt=%0d empty=%b rdy=%b rc=%0d exp 0 1 1 0", count, empty, wr_ready, retry_cnt); end
    checks++; if (start_tx !== 1'b0 || id_std !== 11'h0) begin errors++; $display("FAIL rstb_head got start=%b id=%h exp 0 0", start_tx, id_std); end
    step(); step(); step();
    checks++; if (start_tx !== 1'b0) begin errors++; $display("FAIL rstb_quiet got %b exp 0", start_tx); end
    push(1'b0, 1'b0, 11'h5FF, 29'h0, 4'd1, 64'h0);
    step();
    checks++; if (start_tx !== 1'b1 || id_std !== 11'h5FF) begin errors++; $display("FAIL rstb_new got start=%b id=%h exp 1 5ff", start_tx, id_std); end
    send_ok();
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_ide = 1'b0; wr_rtr = 1'b0; wr_id_std = '0;
    wr_id_ext = '0; wr_dlc = '0; wr_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
    tx_arb_lost = 1'b0; tx_err = 1'b0; abort_req = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_retry();
    test_abort();
    test_simul();
    test_wrap();
    test_rst_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
